// File: rtl/afe_pulser_pkg.sv
// Shared definitions for the AFE pulser trigger path: sequencer state encoding
// and default timing constants.
package afe_pulser_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } seq_state_t;

  localparam int TRIG_LEN_DEF   = 4;
  localparam int MIN_PERIOD_DEF = 8;

  function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                               input logic [31:0] min_period);
    return (period < min_period) ? min_period : period;
  endfunction

endpackage

// File: rtl/afe_pulser_seq_if.sv
// Command/status bundle between software control and the trigger sequencer.
interface afe_pulser_seq_if;
  logic        start;
  logic        stop;
  logic [31:0] period;
  logic [15:0] n_pulses;
  logic        trig;
  logic        busy;
  logic        done;
  logic [15:0] pulse_cnt;

  modport master (
    output start, stop, period, n_pulses,
    input  trig, busy, done, pulse_cnt
  );

  modport slave (
    input  start, stop, period, n_pulses,
    output trig, busy, done, pulse_cnt
  );
endinterface

// File: rtl/afe_pulser_seq.sv
// Trigger sequencer feeding afe_pulser: single shot, counted burst or
// continuous periodic train of fixed-length trig pulses.
//
// state  | meaning
// S_IDLE | waiting for start
// S_HIGH | trig high, high-time counter running
// S_LOW  | trig low, waiting for next period boundary
module afe_pulser_seq
  import afe_pulser_pkg::*;
#(
  parameter int TRIG_LEN   = TRIG_LEN_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input logic             lclk,
  input logic             lclk_rst,
  afe_pulser_seq_if.slave bus
);

  localparam logic [3:0]  HCNT_LOAD = 4'(TRIG_LEN);
  localparam logic [31:0] MIN_P     = 32'(MIN_PERIOD);

  seq_state_t  state;
  logic        trig;
  logic        busy;
  logic        done;
  logic [15:0] pulse_cnt;
  logic [3:0]  hcnt;
  logic [31:0] pcnt;
  logic [31:0] p_eff;
  logic [15:0] n_lat;
  logic        stop_seen;

  // pcnt counts cycles since the last rising edge; p_eff >= 2*TRIG_LEN, so it
  // can only match p_eff while in S_LOW.
  always_ff @(posedge lclk) begin
    if (lclk_rst) begin
      state     <= S_IDLE;
      trig      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
      hcnt      <= '0;
      pcnt      <= '0;
      p_eff     <= '0;
      n_lat     <= '0;
      stop_seen <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            state     <= S_HIGH;
            trig      <= 1'b1;
            busy      <= 1'b1;
            pulse_cnt <= 16'd1;
            hcnt      <= HCNT_LOAD;
            pcnt      <= 32'd1;
            p_eff     <= clamp_period(bus.period, MIN_P);
            n_lat     <= bus.n_pulses;
            stop_seen <= 1'b0;
          end
        end
        S_HIGH: begin
          pcnt <= pcnt + 32'd1;
          if (hcnt == 4'd1) begin
            trig <= 1'b0;
            if (stop_seen || bus.stop || (n_lat != 16'd0 && pulse_cnt == n_lat)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_LOW;
            end
          end else begin
            hcnt <= hcnt - 4'd1;
            if (bus.stop) stop_seen <= 1'b1;
          end
        end
        S_LOW: begin
          if (bus.stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (pcnt == p_eff) begin
            state     <= S_HIGH;
            trig      <= 1'b1;
            hcnt      <= HCNT_LOAD;
            pcnt      <= 32'd1;
            pulse_cnt <= pulse_cnt + 16'd1;
          end else begin
            pcnt <= pcnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.trig      = trig;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pulse_cnt = pulse_cnt;

endmodule

// File: tb/tb_afe_pulser_seq.sv
// Self-checking bench for afe_pulser_seq against a closed-form timing model.
module tb_afe_pulser_seq;

  localparam int L    = 4;
  localparam int MINP = 8;

  logic lclk = 1'b0;
  logic lclk_rst;

  afe_pulser_seq_if bus();

  afe_pulser_seq #(.TRIG_LEN(L), .MIN_PERIOD(MINP)) dut (
    .lclk     (lclk),
    .lclk_rst (lclk_rst),
    .bus      (bus)
  );

  always #5 lclk = ~lclk;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [15:0] last_cnt  = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge lclk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [15:0] cnt);
    check({tag, ".trig"}, 32'(bus.trig), 32'd0);
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".done"}, 32'(bus.done), 32'd0);
    check({tag, ".cnt"},  32'(bus.pulse_cnt), 32'(cnt));
  endtask

  // Start sampled at edge 0; cycle c is the cycle following edge c-1.
  // Pulse k (k>=0) is high on cycles 1+k*p .. k*p+L; the run ends at cycle e.
  task automatic run(input string tag, input logic [31:0] per, input logic [15:0] n,
                     input int stop_at, input int busy_start_at);
    longint p, e, e_fin, e_stop, k, ph;
    logic   exp_trig, exp_busy, exp_done;
    logic [15:0] exp_cnt;
    p      = (longint'(per) < MINP) ? longint'(MINP) : longint'(per);
    e_fin  = (n != 16'd0) ? 1 + (longint'(n) - 1) * p + L : 64'h7fff_ffff_ffff;
    e_stop = 64'h7fff_ffff_ffff;
    if (stop_at > 0) begin
      k  = (stop_at - 1) / p;
      ph = (stop_at - 1) % p;
      e_stop = (ph < L) ? 1 + k * p + L : longint'(stop_at) + 1;
    end
    e = (e_fin < e_stop) ? e_fin : e_stop;

    bus.period   = per;
    bus.n_pulses = n;
    bus.start    = 1'b1;
    bus.stop     = 1'b0;
    step();
    for (longint c = 1; c <= e + 3; c++) begin
      bus.start = (c == longint'(busy_start_at));
      bus.stop  = (c == longint'(stop_at));
      if (c == 3) begin
        bus.period   = $urandom_range(1, 200);
        bus.n_pulses = 16'($urandom_range(0, 9));
      end
      if (c < e) begin
        k        = (c - 1) / p;
        ph       = (c - 1) % p;
        exp_trig = (ph < L);
        exp_busy = 1'b1;
        exp_done = 1'b0;
        exp_cnt  = 16'(k + 1);
      end else begin
        exp_trig = 1'b0;
        exp_busy = 1'b0;
        exp_done = (c == e);
        exp_cnt  = 16'((e - 2) / p + 1);
      end
      check($sformatf("%s.trig@%0d", tag, c), 32'(bus.trig), 32'(exp_trig));
      check($sformatf("%s.busy@%0d", tag, c), 32'(bus.busy), 32'(exp_busy));
      check($sformatf("%s.done@%0d", tag, c), 32'(bus.done), 32'(exp_done));
      check($sformatf("%s.cnt@%0d",  tag, c), 32'(bus.pulse_cnt), 32'(exp_cnt));
      step();
      last_cnt = exp_cnt;
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    logic [31:0] rp;
    logic [15:0] rn;
    int          rs;

    lclk_rst     = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.period   = 32'd0;
    bus.n_pulses = 16'd0;
    #1;
    step();
    step();
    check_idle("reset", 16'd0);
    lclk_rst = 1'b0;
    step();
    check_idle("post_reset", 16'd0);

    run("single", 32'd100, 16'd1, 0, 0);
    run("burst",  32'd10,  16'd3, 0, 0);
    run("clamp",  32'd3,   16'd2, 0, 0);
    run("cont_stop_high", 32'd20, 16'd0, 42, 0);
    run("cont_stop_low",  32'd20, 16'd0, 30, 0);
    run("busy_start", 32'd10, 16'd3, 0, 5);

    // start and stop together in idle: no run begins
    bus.period   = 32'd10;
    bus.n_pulses = 16'd1;
    bus.start    = 1'b1;
    bus.stop     = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle($sformatf("start_stop_idle%0d", i), last_cnt);
      step();
    end

    // stop alone in idle: ignored
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check_idle("stop_idle", last_cnt);

    for (int i = 0; i < 6; i++) begin
      rp = $urandom_range(1, 40);
      rn = 16'($urandom_range(0, 5));
      if (rn == 16'd0 || $urandom_range(0, 1) == 1) rs = $urandom_range(2, 120);
      else rs = 0;
      run($sformatf("rand%0d", i), rp, rn, rs, $urandom_range(2, 4));
    end

    // reset while trig is high
    bus.period   = 32'd100;
    bus.n_pulses = 16'd1;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    check("rst_mid.trig_before", 32'(bus.trig), 32'd1);
    step();
    lclk_rst = 1'b1;
    step();
    check_idle("rst_mid", 16'd0);
    lclk_rst = 1'b0;
    step();
    check_idle("rst_mid_after", 16'd0);

    run("after_reset", 32'd100, 16'd1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/afe_pulser_seq.md
# afe_pulser_seq

Trigger sequencer for the mDOM AFE pulser, in the `lclk` domain directly upstream of `afe_pulser`. It turns a software start command into a single trigger, a counted burst, or a continuous periodic train on `trig`. `trig` drives the `afe_pulser` `trig` input, whose one-shot and synchronizer carry each rising edge into `divclk`. Every trigger pulse is a clean, fixed-length high level so each rising edge is captured exactly once downstream.

## Interface
Parameters:
- `TRIG_LEN`, default 4: `trig` high time in `lclk` cycles per pulse; legal range 1–15.
- `MIN_PERIOD`, default 8: lower clamp on the period; must be ≥ `2*TRIG_LEN`.

Ports:
- `lclk`, in, 1: clock.
- `lclk_rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle start strobe.
- `stop`, in, 1: one-cycle stop strobe.
- `period`, in, 32: `lclk` cycles between successive `trig` rising edges.
- `n_pulses`, in, 16: pulses per run; 0 means continuous.
- `trig`, out, 1: trigger to `afe_pulser`.
- `busy`, out, 1: run in progress.
- `done`, out, 1: one-cycle end-of-run strobe.
- `pulse_cnt`, out, 16: rising edges issued in the current or last run.

## Operation
- All outputs are registered.
- Reset values: `trig`=0, `busy`=0, `done`=0, `pulse_cnt`=0, state `S_IDLE`.
- States:
  - `S_IDLE`: waiting for `start`.
  - `S_HIGH`: `trig`=1, high-time counter running.
  - `S_LOW`: `trig`=0, waiting for the next period boundary.
- `S_IDLE` → `S_HIGH` on `start` with `stop` low.
  - Latch `p_eff = max(period, MIN_PERIOD)` and `n_pulses`.
  - Clear `pulse_cnt`, then count this edge; set `busy`.
- `S_HIGH` → `S_LOW` after `TRIG_LEN` cycles.
- `S_LOW` → `S_HIGH` when `p_eff` cycles have elapsed since the previous rising edge; increment `pulse_cnt`.
- End of run, then go to `S_IDLE`, pulse `done` and clear `busy`. This happens in either case:
  - the last pulse (count reaches the latched `n_pulses`, `n_pulses`≠0) finishes its high phase;
  - `stop` has been seen.
- `stop` in `S_HIGH`: the high phase is never truncated. It completes, then the run ends.
- `stop` in `S_LOW`: the run ends on the next cycle.
- `stop` in `S_IDLE`: ignored.
- `start` while `busy`: ignored.
- `start` and `stop` in the same cycle: `stop` wins, so no run starts.
- `period` and `n_pulses` are sampled only at start. Changes mid-run have no effect.
- `pulse_cnt` wraps modulo 2^16 in continuous mode and holds its value after `done`.
- Period counter is 32 bits and counts from 1 at each rising edge. It never wraps, because the comparison is against `p_eff` ≤ 2^32−1.
- Reset mid-run: all outputs return to their reset values at the next `lclk` edge, and `trig` may truncate. A truncated pulse of ≥1 cycle is still a valid downstream edge.

## Timing
- `start` sampled at edge t:
  - `trig` high for cycles t+1 … t+`TRIG_LEN`;
  - `busy` high from t+1;
  - `pulse_cnt`=1 at t+1.
- k-th rising edge (k ≥ 1) at t+1+(k−1)·`p_eff`.
- Finite run: `done` high for exactly the cycle t+1+(n−1)·`p_eff`+`TRIG_LEN`, the first low cycle after the last pulse. `busy` is low in that same cycle.
- Stop in `S_LOW` at edge s: `done` at s+1. `busy` is low from s+1.
- Minimum `trig` low time is `p_eff − TRIG_LEN` ≥ `TRIG_LEN`. This keeps the downstream one-shot re-armed.

## Structure
- Shared package `afe_pulser_pkg`: state encoding `S_IDLE`/`S_HIGH`/`S_LOW` and default constants `TRIG_LEN_DEF`=4 and `MIN_PERIOD_DEF`=8.
- Single flat module. The high-time counter, the period counter and the pulse counter are inline.
- No sub-module.

## Test plan
- Single pulse: `n_pulses`=1, `period`=100, `start` at t.
  - `trig`=1 on t+1…t+4.
  - `done` at t+5; `busy` 1 on t+1…t+4.
  - `pulse_cnt`=1.
- Burst: `n_pulses`=3, `period`=10.
  - Rising edges at t+1, t+11, t+21.
  - `done` at t+25; `pulse_cnt`=3.
- Clamp: `period`=3, `n_pulses`=2.
  - Rising edges at t+1 and t+9.
  - `done` at t+13.
- Continuous with stop: `n_pulses`=0, `period`=20.
  - `stop` during a high phase: the high phase completes, then `done` fires in the first low cycle.
  - `stop` during a low phase at s: `done` at s+1.
  - No further rising edges after stop.
- Command collisions:
  - `start`+`stop` together in idle: nothing happens.
  - `start` while busy: ignored.
  - `period` changed mid-run: spacing stays unchanged.
- Reset mid-run: assert `lclk_rst` during `S_HIGH`.
  - Next cycle: `trig`=`busy`=`done`=0 and `pulse_cnt`=0.
  - A later `start` behaves as in the first test.
